// File: rtl/tick_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer_bank
//  Description : Bank of CHANNELS independent programmable tick generators.
//                Each channel counts clock cycles up to a programmable period
//                and emits a registered one-cycle tick on wrap.
//                Channels run periodic or one-shot, can be paused, started,
//                restarted and stopped.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   system clock, all logic on posedge
//    resetn         in   synchronous active-low reset
//    en_i           in   per-channel count enable (low pauses the channel)
//    mode_i         in   per-channel mode, 0 periodic / 1 one-shot (at start)
//    start_i        in   per-channel start / restart strobe
//    stop_i         in   per-channel stop strobe (wins over start)
//    load_i         in   period write strobe
//    load_ch_i      in   channel index for the period write
//    load_period_i  in   new period value
//    tick_o         out  registered one-cycle tick per channel
//    busy_o         out  high while the channel is running
// ============================================================================
module tick_timer_bank #(
  parameter int unsigned      WIDTH          = 26,
  parameter int unsigned      CHANNELS       = 4,
  parameter int unsigned      CH_BITS        = 2,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(50000000)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] en_i,
  input  logic [CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0] start_i,
  input  logic [CHANNELS-1:0] stop_i,
  input  logic                load_i,
  input  logic [CH_BITS-1:0]  load_ch_i,
  input  logic [WIDTH-1:0]    load_period_i,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;

    logic             load_hit;
    logic             at_wrap;
    logic [WIDTH-1:0] start_period;

    // Indices beyond the channel count never match any channel, so such
    // writes are dropped without extra logic.
    assign load_hit     = load_i && (load_ch_i == CH_BITS'(c));

    // Period that a start would make active.
    assign start_period = pend_valid_q ? pend_q : period_q;

    // A running channel never holds period 0, so period-1 cannot underflow
    // in any state where this compare is used.
    assign at_wrap      = (count_q == (period_q - WIDTH'(1)));

    always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      period_d     = period_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      mode_d       = mode_q;
      tick_d       = 1'b0;

      if (stop_i[c]) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else if (start_i[c]) begin
        // A start with an effective period of zero is ignored entirely,
        // leaving the channel (and its pending value) untouched.
        if (start_period != '0) begin
          state_d      = ST_RUN;
          count_d      = '0;
          period_d     = start_period;
          pend_valid_d = 1'b0;
          mode_d       = mode_i[c];
        end
      end else if ((state_q == ST_RUN) && en_i[c]) begin
        if (at_wrap) begin
          tick_d  = 1'b1;
          count_d = '0;
          if (mode_q) begin
            state_d = ST_IDLE;
          end else if (pend_valid_q) begin
            period_d     = pend_q;
            pend_valid_d = 1'b0;
            // A pending zero period stops the channel after this tick.
            if (pend_q == '0) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end

      // Evaluated last so a write on the same edge as a start or wrap is kept
      // pending for the next one rather than being consumed immediately.
      if (load_hit) begin
        pend_d       = load_period_i;
        pend_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (!resetn) begin
        state_q      <= ST_IDLE;
        count_q      <= '0;
        period_q     <= DEFAULT_PERIOD;
        pend_q       <= DEFAULT_PERIOD;
        pend_valid_q <= 1'b0;
        mode_q       <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        state_q      <= state_d;
        count_q      <= count_d;
        period_q     <= period_d;
        pend_q       <= pend_d;
        pend_valid_q <= pend_valid_d;
        mode_q       <= mode_d;
        tick_q       <= tick_d;
      end
    end

    assign tick_o[c] = tick_q;
    assign busy_o[c] = (state_q == ST_RUN);

  end : g_ch

endmodule : tick_timer_bank
`default_nettype wire

// File: doc/tick_timer_bank.md
# tick_timer_bank

Multi-channel programmable tick generator for the game's timing layer. It replaces the single fixed one-second delay counter with CHANNELS independent timers: per-channel period, periodic or one-shot mode, pause/enable, and start/stop control. Each channel emits a one-cycle `tick` pulse. Ball motion, paddle sampling, and display blink logic consume the ticks as clock enables in the `clock` domain.

## Interface
- `WIDTH`, 26: counter and period width in bits.
- `CHANNELS`, 4: number of independent timer channels.
- `CH_BITS`, 2: width of the channel index; must satisfy 2^CH_BITS >= CHANNELS.
- `DEFAULT_PERIOD`, 50000000: period loaded into every channel at reset; one second at 50 MHz.

Ports (clock and reset first):
- `clock`  in  1  system clock; all logic is posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `en`  in  CHANNELS  per-channel count enable; low pauses the channel.
- `mode`  in  CHANNELS  per-channel mode; 0 = periodic, 1 = one-shot. Sampled at start.
- `start`  in  CHANNELS  per-channel start/restart strobe.
- `stop`  in  CHANNELS  per-channel stop strobe.
- `load`  in  1  period write strobe.
- `load_ch`  in  CH_BITS  channel index for the period write.
- `load_period`  in  WIDTH  new period value P.
- `tick`  out  CHANNELS  registered one-cycle pulse per channel.
- `busy`  out  CHANNELS  high while the channel is in RUN.

## Operation
- Each channel holds:
  - `count` (WIDTH bits)
  - `period` (active)
  - `pend` (pending period) with a `pend_valid` flag
  - `mode_q` (mode latched at start)
  - a 2-state FSM: IDLE, RUN
- Reset (`resetn` = 0 at an edge), whatever state the channels are in:
  - FSM → IDLE; `count` = 0; `tick` = 0; `busy` = 0.
  - `period` = `pend` = DEFAULT_PERIOD; `pend_valid` = 0.
- Period load: with `load` = 1 and `load_ch` < CHANNELS, `pend[load_ch]` ← `load_period` and `pend_valid` ← 1.
  - An index >= CHANNELS is ignored.
  - The pending value is copied to `period` only on a start or at a RUN wrap. A running count is never cut short by a load.
- IDLE → RUN on `start`:
  - `count` ← 0.
  - `period` ← `pend` if `pend_valid`, and `pend_valid` is cleared.
  - `mode_q` ← `mode`.
- RUN, `en` = 1, `count` == `period`-1: `tick` ← 1 for one cycle.
  - Periodic: `count` ← 0 and the pending period is applied.
  - One-shot: the channel goes to IDLE and `count` ← 0.
- RUN, `en` = 1, otherwise: `count` ← `count` + 1.
- RUN, `en` = 0: `count` and the state are held; no tick. `start` and `stop` are still honoured.
- `start` while in RUN restarts the channel (same actions as IDLE → RUN). No tick is emitted on that edge.
- `stop` at any time: IDLE, `count` ← 0, no tick. `stop` wins over a simultaneous `start`.
- Period 0: `start` is ignored and the channel stays IDLE.
  - If a pending 0 is applied at a periodic wrap, the channel goes to IDLE after emitting that wrap's tick.
- Channels are fully independent. Simultaneous ticks on several channels are legal.
- Arithmetic is unsigned WIDTH bits. `count` never exceeds `period`-1, so it never wraps through 2^WIDTH.

## Timing
- `tick` and `busy` are registered; no combinational path from any input to any output.
- With `start` sampled at edge E0 and `en` held high, `busy` is high after E0.
  - Periodic: `tick` is high after edges E(P), E(2P), …
  - One-shot: `tick` is high only after E(P); `busy` falls at the same edge E(P).
- P = 1, periodic: `tick` is high after every edge from E1 on; it stays continuously high while the channel runs.
- Pausing for k cycles (`en` low) delays every subsequent tick by exactly k cycles.
- `load` at edge E takes effect no earlier than the next wrap or start edge after E.
  - When `load` and a wrap for the same channel fall on the same edge, the old `pend` is applied. The new value waits for the following wrap.

## Test plan
Parameters for all scenarios: WIDTH=8, CHANNELS=2, CH_BITS=1, DEFAULT_PERIOD=5.

- Reset, then `start[0]` at E0, periodic → `tick[0]` high after E5, E10, E15; `busy[0]` = 1 from E0; `tick[1]` = 0 throughout.
- `load` ch1 P=3, then `start[1]` one-shot → a single `tick[1]` 3 cycles after start; `busy[1]` drops on the same edge; no further ticks.
- Ch0 periodic P=5; `en[0]` low for 4 cycles starting at E2 → ticks after E9 and E14.
- Ch0 running; `load` P=2 at E3 → next tick still after E5; subsequent ticks after E7, E9.
- `start[0]` and `stop[0]` on the same edge while running → IDLE, `count` 0, no tick.
- `resetn` low mid-count (E3) → `tick` = `busy` = 0; a restart yields a tick 5 cycles later. Also: `load` P=0 then `start` → channel stays IDLE.
